pow2_scale_pipe: RTL and testbench
==================================

Name: pow2_scale_pipe

Overview:
- Fixed-point power-of-two scaler for the digital-filter datapath. Handles gain staging between filter sections and coefficient normalisation.
- Multiplies a signed Q(width_H).(width_W) sample by 2^k. The shift k is a signed value supplied per sample at run time.
- Optional round-to-nearest on right shifts; saturation on overflow.
- Two-stage pipeline with valid/ready backpressure, a per-sample saturation flag and a sticky saturation event counter.

Parameters:
- width_H, 5, integer bits of the sample including sign.
- width_W, 20, fractional bits.
- SHIFT_W, 6, width of the signed run-time shift input.
- ROUND, 1, right-shift mode: 1 = round half up, 0 = truncate (floor).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- data_i_en  in  1  input sample valid.
- data_i_rdy  out  1  block can accept a sample this cycle.
- data_i  in  width_H+width_W  signed input sample.
- shift_i  in  SHIFT_W  signed shift k: positive = left (multiply), negative = right (divide). Sampled together with data_i.
- data_o_en  out  1  output sample valid.
- data_o_rdy  in  1  downstream accepts the output this cycle.
- data_o  out  width_H+width_W  signed scaled result.
- sat_o  out  1  data_o was saturated; qualified by data_o_en.
- sat_cnt  out  CNT_W  count of saturated output transfers, saturating at all-ones.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Definitions: W = width_H+width_W. A transfer occurs on an edge where valid and ready are both 1.
- Reset (rst==0): both stage valids = 0; data_o_en = 0, data_o = 0, sat_o = 0, sat_cnt = 0. Any in-flight samples are discarded. Reset overrides every other input.
- Stage 1 (S1): on an input transfer, registers data_i and shift_i and sets v1 = 1.
- Stage 2 (S2, the output register): computes the result from the S1 contents, then registers data_o, sat_o and data_o_en.
- Advance rule: S2 loads when it is empty or its output is transferring this cycle, i.e. adv2 = !data_o_en || data_o_rdy.
- data_i_rdy = !v1 || adv2 (combinational). S1 loads on an input transfer; otherwise v1 is cleared when its contents move to S2.
- Throughput: one sample per cycle with no stall. Latency: 2 cycles from the input transfer to data_o_en.
- Under stall, S1 and S2 hold their contents, no sample is lost or duplicated, and order is preserved.
- Arithmetic is evaluated as if in unbounded precision on sign-extended values. This applies to any |k|, including |k| >= W.
  - k >= 0: r = x·2^k.
  - k < 0, m = -k, ROUND=0: r = floor(x/2^m), i.e. arithmetic shift right.
  - k < 0, m = -k, ROUND=1: r = floor((x + 2^(m-1))/2^m).
- Saturation:
  - If r > 2^(W-1)-1, then data_o = 2^(W-1)-1 and sat_o = 1.
  - If r < -2^(W-1), then data_o = -2^(W-1) and sat_o = 1.
  - Otherwise data_o = r and sat_o = 0.
- k = 0 passes x through unchanged with sat_o = 0.
- x = 0 yields 0 for any k.
- Right shift with m >= W yields 0 or -1 (ROUND=0) and 0 (ROUND=1); never saturates.
- sat_cnt increments by 1 on each output transfer with sat_o = 1, and holds at 2^CNT_W-1.
- sat_clr has priority over increment: on a cycle with both, sat_cnt = 0.
- While data_o_en = 0, data_o and sat_o hold their last values; they are not cleared.

Test Plan:
- Reset and passthrough (W=25, ROUND=1): hold rst=0 for 2 cycles, release; send x=0x0100000 (1.0), k=+2 → 2 cycles later data_o=0x0400000, sat_o=0, sat_cnt=0.
- Positive saturation: x=0x0800000 (8.0), k=+2 → data_o=0x0FFFFFF, sat_o=1, sat_cnt=1. Negative saturation: x=0x1800000 (-8.0), k=+3 → data_o=0x1000000, sat_o=1, sat_cnt=2.
- Rounding, right shift by 1 (k=-1):
  - ROUND=1: x=3 → 2; x=-3 → -1 (0x1FFFFFF).
  - ROUND=0: x=3 → 1; x=-3 → -2 (0x1FFFFFE).
  - Either mode: x=0x1000000, k=-31 → 0 (ROUND=1) / 0x1FFFFFF (ROUND=0), sat_o=0.
- Backpressure: stream 8 samples with data_i_en=1 and data_o_rdy=0 for cycles 3–5 → data_i_rdy falls once S1 and S2 are full; all 8 results emerge in order; no drops or duplicates; back-to-back output when unstalled.
- Counter: force 3 saturating transfers → sat_cnt=3; assert sat_clr in the same cycle as a 4th saturating transfer → sat_cnt=0. With CNT_W=2, 5 saturations → sat_cnt=3 (holds).
- Reset mid-operation: pull rst=0 while both stages are valid and the output is stalled → next cycle data_o_en=0, data_o=0, sat_cnt=0, data_i_rdy=1; the old samples never appear.

Source files
------------

// File: rtl/pow2_scale_pipe.sv
// Two-stage signed fixed-point scaler by 2^k, with optional rounding on right
// shifts, saturation to the sample range, and a sticky saturation counter.
module pow2_scale_pipe #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int SHIFT_W = 6,
  parameter int ROUND   = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_i_en,
  output logic                       data_i_rdy,
  input  logic [width_H+width_W-1:0] data_i,
  input  logic [SHIFT_W-1:0]         shift_i,
  output logic                       data_o_en,
  input  logic                       data_o_rdy,
  output logic [width_H+width_W-1:0] data_o,
  output logic                       sat_o,
  output logic [CNT_W-1:0]           sat_cnt,
  input  logic                       sat_clr
);
  localparam int W = width_H + width_W;
  // Wide enough for the largest left shift and the rounding bias of the largest right shift.
  localparam int EXT = W + (1 << (SHIFT_W-1)) + 2;
  localparam logic signed [EXT-1:0] MAXE = {{(EXT-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [EXT-1:0] MINE = ~MAXE;
  localparam logic signed [EXT-1:0] ONE  = {{(EXT-1){1'b0}}, 1'b1};

  logic                      v1_q;
  logic signed [W-1:0]       x1_q;
  logic signed [SHIFT_W-1:0] k1_q;
  logic                      vo_q, sat_q;
  logic [W-1:0]              dout_q;
  logic [CNT_W-1:0]          cnt_q;

  logic adv2, in_xfer, out_xfer;
  assign adv2       = !vo_q || data_o_rdy;
  assign data_i_rdy = !v1_q || adv2;
  assign in_xfer    = data_i_en && data_i_rdy;
  assign out_xfer   = vo_q && data_o_rdy;

  assign data_o_en = vo_q;
  assign data_o    = dout_q;
  assign sat_o     = sat_q;
  assign sat_cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      k1_q <= '0;
    end else if (in_xfer) begin
      v1_q <= 1'b1;
      x1_q <= data_i;
      k1_q <= shift_i;
    end else if (adv2) begin
      v1_q <= 1'b0;
    end
  end

  logic signed [EXT-1:0] xe, bias, sum, re;
  logic [SHIFT_W-1:0]    m, m_m1;
  logic [W-1:0]          res_d;
  logic                  sat_d;

  always_comb begin
    xe   = {{(EXT-W){x1_q[W-1]}}, x1_q};
    m    = SHIFT_W'(-k1_q);
    m_m1 = m - SHIFT_W'(1);
    bias = '0;
    sum  = xe;
    if (!k1_q[SHIFT_W-1]) begin
      re = xe <<< k1_q;
    end else begin
      // Round half up: add 2^(m-1) before the flooring arithmetic shift.
      if (ROUND != 0) bias = ONE <<< m_m1;
      sum = xe + bias;
      re  = sum >>> m;
    end
    sat_d = 1'b1;
    if (re > MAXE)      res_d = MAXE[W-1:0];
    else if (re < MINE) res_d = MINE[W-1:0];
    else begin
      res_d = re[W-1:0];
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vo_q   <= 1'b0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv2) begin
      vo_q <= v1_q;
      if (v1_q) begin
        dout_q <= res_d;
        sat_q  <= sat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || sat_clr)                       cnt_q <= '0;
    else if (out_xfer && sat_q && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_pow2_scale_pipe.sv
// Scoreboard bench: two scalers (round/16-bit count, floor/2-bit count) share stimulus.
module tb_pow2_scale_pipe;
  localparam int W = 25;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic         data_i_en = 1'b0, data_o_rdy = 1'b1, sat_clr = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [5:0]   shift_i = '0;
  logic         rdy1, rdy0, en1, en0, sat1, sat0;
  logic [W-1:0] do1, do0;
  logic [15:0]  cnt1;
  logic [1:0]   cnt0;

  pow2_scale_pipe #(.ROUND(1), .CNT_W(16)) u_r1 (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i_rdy(rdy1), .data_i(data_i),
    .shift_i(shift_i), .data_o_en(en1), .data_o_rdy(data_o_rdy), .data_o(do1),
    .sat_o(sat1), .sat_cnt(cnt1), .sat_clr(sat_clr));
  pow2_scale_pipe #(.ROUND(0), .CNT_W(2)) u_r0 (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i_rdy(rdy0), .data_i(data_i),
    .shift_i(shift_i), .data_o_en(en0), .data_o_rdy(data_o_rdy), .data_o(do0),
    .sat_o(sat0), .sat_cnt(cnt0), .sat_clr(sat_clr));

  int total = 0, bad = 0;
  bit mon_on = 0, saw_stall = 0, rnd_done = 0;
  logic [W:0] q1[$], q0[$];
  longint ce1 = 0, ce0 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unbounded-precision x*2^k, floor division for right shifts, then clamp.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [5:0] k, input bit rnd);
    longint xs, r, d, n, mx, mn;
    int ki;
    xs = $signed(x);
    ki = $signed(k);
    if (ki >= 0) r = xs * (64'sd1 <<< ki);
    else begin
      d = 64'sd1 <<< (-ki);
      n = xs + (rnd ? d / 2 : 0);
      r = n / d;
      if ((n % d) != 0 && n < 0) r = r - 1;
    end
    mx = (64'sd1 <<< (W-1)) - 1;
    mn = -(64'sd1 <<< (W-1));
    if (r > mx) return {1'b1, mx[W-1:0]};
    if (r < mn) return {1'b1, mn[W-1:0]};
    return {1'b0, r[W-1:0]};
  endfunction

  always @(negedge clk) begin : mon
    logic [W:0] e;
    bit inc1, inc0;
    if (mon_on) begin
      chk("cnt1", cnt1, ce1);
      chk("cnt0", cnt0, ce0);
      chk("rdy_match", rdy0, rdy1);
      if (!rst) begin
        q1.delete(); q0.delete(); ce1 = 0; ce0 = 0;
      end else begin
        if (!rdy1) saw_stall = 1;
        inc1 = 0; inc0 = 0;
        if (en1 && data_o_rdy) begin
          chk("q1_nonempty", q1.size() != 0, 1);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("data1", do1, e[W-1:0]); chk("sat1", sat1, e[W]); inc1 = e[W];
          end
        end
        if (en0 && data_o_rdy) begin
          chk("q0_nonempty", q0.size() != 0, 1);
          if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("data0", do0, e[W-1:0]); chk("sat0", sat0, e[W]); inc0 = e[W];
          end
        end
        ce1 = sat_clr ? 0 : (inc1 && ce1 != 65535) ? ce1 + 1 : ce1;
        ce0 = sat_clr ? 0 : (inc0 && ce0 != 3) ? ce0 + 1 : ce0;
        if (data_i_en && rdy1) begin
          q1.push_back(model(data_i, shift_i, 1));
          q0.push_back(model(data_i, shift_i, 0));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [W-1:0] x, input logic [5:0] k);
    data_i_en = 1'b1; data_i = x; shift_i = k;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy1) break;
    end
    chk("send_accept", rdy1, 1);
    @(posedge clk); #1;
    data_i_en = 1'b0;
  endtask

  localparam logic [W-1:0] SATP = 25'h0800000;

  initial begin
    @(posedge clk); mon_on = 1;
    @(posedge clk); #1;
    chk("rst_en", en1, 0); chk("rst_data", do1, 0); chk("rst_sat", sat1, 0);
    chk("rst_rdy", rdy1, 1);
    rst = 1'b1;

    send(25'h0100000, 6'd2); idle(3);
    send(SATP, 6'd2); idle(3); chk("cnt_pos", cnt1, 1);
    send(25'h1800000, 6'd3); idle(3); chk("cnt_neg", cnt1, 2);
    send(25'd3, 6'h3F); send(25'h1FFFFFD, 6'h3F); send(25'h1000000, 6'h21);
    send(25'h0, 6'h1F); send(25'h0ABCDE, 6'd0); send(25'h1FFFFFF, 6'h20);
    idle(3);

    saw_stall = 0;
    fork
      for (int i = 0; i < 8; i++) send(25'($urandom_range(0, 4095)) - 25'd2048, 6'($urandom_range(0, 8)) - 6'd4);
      begin idle(2); data_o_rdy = 1'b0; idle(3); data_o_rdy = 1'b1; end
    join
    idle(4);
    chk("stall_seen", saw_stall, 1);

    sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
    repeat (3) send(SATP, 6'd2);
    idle(3); chk("cnt3_r1", cnt1, 3); chk("cnt3_r0", cnt0, 3);
    data_o_rdy = 1'b0;
    send(SATP, 6'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en1) break;
    end
    @(posedge clk); #1;
    data_o_rdy = 1'b1; sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
    chk("cnt_clr", cnt1, 0);
    repeat (5) send(25'h1800000, 6'd5);
    idle(3); chk("cnt5_r1", cnt1, 5); chk("cnt_hold_r0", cnt0, 3);

    fork
      begin
        for (int i = 0; i < 300; i++)
          send(($urandom_range(0, 1) != 0) ? 25'($urandom) : 25'($urandom_range(0, 63)) - 25'd32,
               6'($urandom));
        rnd_done = 1;
      end
      while (!rnd_done) begin data_o_rdy = ($urandom_range(0, 3) != 0); idle(1); end
    join
    data_o_rdy = 1'b1; idle(4);

    data_o_rdy = 1'b0;
    send(SATP, 6'd4); send(25'h0123456, 6'd1);
    idle(1);
    rst = 1'b0; idle(1);
    chk("mrst_en", en1, 0); chk("mrst_data", do1, 0); chk("mrst_sat", sat1, 0);
    chk("mrst_cnt", cnt1, 0); chk("mrst_rdy", rdy1, 1);
    rst = 1'b1; data_o_rdy = 1'b1; idle(6);
    chk("drain_q1", q1.size(), 0); chk("drain_q0", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
